// File: rtl/vic_pkg.sv
// Shared types and constants for the vector unit of the vectored interrupt controller.
package vic_pkg;

    localparam int NUM_SRC = 31;
    localparam int IDX_W   = 5;
    localparam int VEC_W   = 32;

    localparam logic [IDX_W-1:0] SPURIOUS_IDX = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } vic_vu_state_t;

    // Reset contents of table entry n: a 4-byte stride from the base address.
    function automatic logic [VEC_W-1:0] default_vector(input logic [VEC_W-1:0] base,
                                                        input int unsigned n);
        return base + (VEC_W'(n) << 2);
    endfunction

endpackage

// File: rtl/vic_vector_unit_if.sv
// Bundle of controller-side, CPU-side and table-programming signals of the vector unit.
interface vic_vector_unit_if;
    import vic_pkg::*;

    logic             i_irq;
    logic [IDX_W-1:0] i_irq_addr;
    logic             i_wr_en;
    logic [IDX_W-1:0] i_wr_idx;
    logic [VEC_W-1:0] i_wr_data;
    logic             i_cpu_ack;
    logic             i_cpu_eoi;
    logic             i_clr_status;

    logic             o_busy;
    logic             o_cpu_irq;
    logic [VEC_W-1:0] o_vector;
    logic [IDX_W-1:0] o_cur_src;
    logic             o_overrun;
    logic             o_timeout;

    // Side that drives the requests, acks and table writes.
    modport master (
        output i_irq, i_irq_addr, i_wr_en, i_wr_idx, i_wr_data,
               i_cpu_ack, i_cpu_eoi, i_clr_status,
        input  o_busy, o_cpu_irq, o_vector, o_cur_src, o_overrun, o_timeout
    );

    // The vector unit itself.
    modport slave (
        input  i_irq, i_irq_addr, i_wr_en, i_wr_idx, i_wr_data,
               i_cpu_ack, i_cpu_eoi, i_clr_status,
        output o_busy, o_cpu_irq, o_vector, o_cur_src, o_overrun, o_timeout
    );

endinterface

// File: rtl/vic_vec_table.sv
// Programmable 31-entry handler-address table with a vector register loaded at capture time.
module vic_vec_table
    import vic_pkg::*;
#(
    parameter logic [VEC_W-1:0] VEC_BASE     = 32'h0000_0080,
    parameter logic [VEC_W-1:0] SPURIOUS_VEC = 32'h0000_007C
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [VEC_W-1:0] wr_data_i,
    input  logic             cap_en_i,
    input  logic [IDX_W-1:0] cap_idx_i,
    output logic [VEC_W-1:0] vec_o
);

    logic [VEC_W-1:0] table_q [0:NUM_SRC-1];
    logic [VEC_W-1:0] vec_q;

    // Table storage: one write per cycle, the spurious index has no entry and is dropped.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int n = 0; n < NUM_SRC; n++) begin
                table_q[n] <= default_vector(VEC_BASE, n);
            end
        end else if (wr_en_i && (wr_idx_i != SPURIOUS_IDX)) begin
            table_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Vector register: sampled only at capture, so it sees the pre-write entry and ignores later writes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vec_q <= '0;
        end else if (cap_en_i) begin
            vec_q <= (cap_idx_i == SPURIOUS_IDX) ? SPURIOUS_VEC : table_q[cap_idx_i];
        end
    end

    assign vec_o = vec_q;

endmodule

// File: rtl/vic_vector_unit.sv
// Vector unit: captures interrupts, presents the handler vector to the CPU and tracks ack/EOI.
module vic_vector_unit
    import vic_pkg::*;
#(
    parameter logic [VEC_W-1:0] VEC_BASE     = 32'h0000_0080,
    parameter logic [VEC_W-1:0] SPURIOUS_VEC = 32'h0000_007C,
    parameter int unsigned      ACK_TIMEOUT  = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    vic_vector_unit_if.slave   bus
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(ACK_TIMEOUT);

    vic_vu_state_t    state_q, state_d;
    logic             hold_vld_q, hold_vld_d;
    logic [IDX_W-1:0] hold_src_q, hold_src_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0] cur_src_q, cur_src_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;

    logic             cap_en;
    logic [IDX_W-1:0] cap_idx;
    logic             timeout_hit;
    logic             cpu_irq;
    logic             busy;

    // A new service starts from IDLE either from the hold register (older) or a fresh pulse.
    assign cap_en      = (state_q == ST_IDLE) && (hold_vld_q || bus.i_irq);
    assign cap_idx     = hold_vld_q ? hold_src_q : bus.i_irq_addr;
    assign timeout_hit = (state_q == ST_REQ) && !bus.i_cpu_ack
                         && ((cnt_q + 16'd1) == TIMEOUT_CNT);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack arriving on the timeout edge still wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cap_en) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.i_cpu_ack) begin
                    state_d = ST_SERVICE;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (bus.i_cpu_eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the state register only, so no input reaches an output combinationally.
    always_comb begin
        cpu_irq = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            ST_REQ: begin
                cpu_irq = 1'b1;
                busy    = 1'b1;
            end
            ST_SERVICE: begin
                busy    = 1'b1;
            end
            default: begin
                cpu_irq = 1'b0;
                busy    = 1'b0;
            end
        endcase
    end

    // Hold register, ack counter, current source and sticky flag next-state.
    always_comb begin
        hold_vld_d = hold_vld_q;
        hold_src_d = hold_src_q;
        cnt_d      = (state_q == ST_REQ) ? (cnt_q + 16'd1) : 16'd0;
        cur_src_d  = cap_en ? cap_idx : cur_src_q;
        overrun_d  = bus.i_clr_status ? 1'b0 : overrun_q;
        timeout_d  = bus.i_clr_status ? 1'b0 : timeout_q;

        if ((state_q == ST_IDLE) && hold_vld_q) begin
            hold_vld_d = 1'b0;
        end
        if (bus.i_irq && !((state_q == ST_IDLE) && !hold_vld_q)) begin
            hold_vld_d = 1'b1;
            hold_src_d = bus.i_irq_addr;
        end

        if (bus.i_irq && (state_q != ST_IDLE) && hold_vld_q) begin
            overrun_d = 1'b1;
        end
        if (timeout_hit) begin
            timeout_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            hold_vld_q <= 1'b0;
            hold_src_q <= '0;
            cnt_q      <= '0;
            cur_src_q  <= '0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            hold_vld_q <= hold_vld_d;
            hold_src_q <= hold_src_d;
            cnt_q      <= cnt_d;
            cur_src_q  <= cur_src_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    vic_vec_table #(
        .VEC_BASE     (VEC_BASE),
        .SPURIOUS_VEC (SPURIOUS_VEC)
    ) u_table (
        .clk_i     (i_clk),
        .rst_n_i   (i_rst),
        .wr_en_i   (bus.i_wr_en),
        .wr_idx_i  (bus.i_wr_idx),
        .wr_data_i (bus.i_wr_data),
        .cap_en_i  (cap_en),
        .cap_idx_i (cap_idx),
        .vec_o     (bus.o_vector)
    );

    assign bus.o_busy    = busy;
    assign bus.o_cpu_irq = cpu_irq;
    assign bus.o_cur_src = cur_src_q;
    assign bus.o_overrun = overrun_q;
    assign bus.o_timeout = timeout_q;

endmodule
